umich_scan_loader: RTL and testbench
====================================

UMICH_SCAN_LOADER -- requirements
Module: umich_scan_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of downstream sequential bits loaded per sequence (2..64).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, number of cycles clear_out and enable_out are each held (1..255).
REQ-003 SHALL have port clocked_on, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port preset, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load sequence.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of an in-progress sequence.
REQ-007 SHALL have port ser_valid, input, 1, serial beat valid.
REQ-008 SHALL have port ser_data, input, 1, serial beat data, LSB of pattern first.
REQ-009 SHALL have port ser_ready, output, 1, loader accepts a serial beat this cycle.
REQ-010 SHALL have port data_out, output, WIDTH, pattern driven to the data_in pins of the downstream bit bank.
REQ-011 SHALL have port enable_out, output, 1, latch enable for the downstream bank.
REQ-012 SHALL have port clear_out, output, 1, clear for the downstream bank.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, CLEAR, SHIFT, LATCH and DONE, with all outputs driven from registers.
REQ-016 IDLE: start=1 -> CLEAR next cycle; all other inputs ignored.
REQ-017 CLEAR: clear_out=1 for exactly HOLD_CYCLES cycles, then SHIFT; shadow register zeroed on entry.
REQ-018 SHIFT: ser_ready=1; each cycle with ser_valid=1, ser_data is written into shadow bit index = beat count (LSB first).
REQ-019 SHIFT: after beat WIDTH-1 is accepted -> LATCH next cycle; ser_ready=0 from that cycle onward.
REQ-020 SHIFT: cycles with ser_valid=0 are stalls, no count change, no timeout.
REQ-021 On entry to LATCH, data_out SHALL load the shadow; data_out SHALL change only on this transition and on reset.
REQ-022 LATCH: enable_out=1 for exactly HOLD_CYCLES cycles with data_out stable, then DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 start SHALL be ignored in every state but IDLE, including DONE.
REQ-025 abort=1 in CLEAR, SHIFT or LATCH -> IDLE next cycle; clear_out, enable_out and ser_ready deasserted; data_out unchanged; done not pulsed.
REQ-026 abort=1 simultaneous with the final accepted beat: abort wins, the beat is discarded, and data_out is unchanged.
REQ-027 Beat and hold counters SHALL be sized to $clog2(max(WIDTH,HOLD_CYCLES)+1) bits and SHALL not wrap.
REQ-028 clear_out and enable_out SHALL never be high in the same cycle.

Reset
REQ-029 preset=1 SHALL asynchronously force state IDLE, shadow=0, data_out=0, counters=0, and clear_out, enable_out, ser_ready, busy and done=0.
REQ-030 preset asserted mid-sequence SHALL abandon the sequence; the first start after deassertion begins a fresh sequence.
REQ-031 The first rising clocked_on edge at which preset is low SHALL be able to accept start.

Structure
REQ-032 State encoding and default WIDTH/HOLD_CYCLES constants SHALL live in shared package umich_scan_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the shadow register and counters are inline.

Verification
REQ-034 WIDTH=16, HOLD=4: start, stream 0xA5C3 LSB-first with no stalls -> clear_out high 4 cycles, 16 beats, data_out=0xA5C3, enable_out high 4 cycles, done pulse; done occurs 26 cycles after start.
REQ-035 Same pattern with ser_valid low on every other cycle -> identical data_out=0xA5C3; SHIFT lasts 32 cycles; no extra beats accepted.
REQ-036 Complete a sequence loading 0xFFFF, then start a second sequence and abort after beat 8 -> return to IDLE, data_out stays 0xFFFF, no done pulse.
REQ-037 Assert preset during LATCH cycle 2 -> all outputs 0 immediately, without waiting for a clock edge; next start followed by a load of 0x0001 completes normally.
REQ-038 Pulse start during SHIFT and during DONE -> no effect; exactly one done pulse per sequence.
REQ-039 Over all scenarios, assert clear_out&enable_out is never 1 and data_out never changes while enable_out=1.

Source files
------------

// File: rtl/umich_scan_pkg.sv
// Shared state encoding and default sizing for the scan-chain loader.
// The counter width is derived from the widest count that any counter has to hold.
package umich_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StShift,
        StLatch,
        StDone
    } state_e;

    localparam int unsigned DefWidth      = 16;
    localparam int unsigned DefHoldCycles = 4;

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned hold);
        int unsigned m;
        m = (width > hold) ? width : hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/umich_scan_loader.sv
// Shifts a serial pattern LSB-first into a shadow register and then presents it to a
// downstream bit bank, using a clear pulse before the load and a latch-enable pulse after it.
module umich_scan_loader
    import umich_scan_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
    input  logic             clocked_on,
    input  logic             preset,
    input  logic             start,
    input  logic             abort,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             enable_out,
    output logic             clear_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = cnt_width(WIDTH, HOLD_CYCLES);
    localparam logic [CntW-1:0] LastBeat = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] LastHold = CntW'(HOLD_CYCLES - 1);

    state_e           r_state_q, w_state_d;
    logic [CntW-1:0]  r_beat_q, w_beat_d;
    logic [CntW-1:0]  r_hold_q, w_hold_d;
    logic [WIDTH-1:0] r_shadow_q, w_shadow_d;
    logic [WIDTH-1:0] r_data_q, w_data_d;
    logic             r_clear_q, w_clear_d;
    logic             r_enable_q, w_enable_d;
    logic             r_ready_q, w_ready_d;
    logic             r_busy_q, w_busy_d;
    logic             r_done_q, w_done_d;

    always_comb begin
        w_state_d  = r_state_q;
        w_beat_d   = r_beat_q;
        w_hold_d   = r_hold_q;
        w_shadow_d = r_shadow_q;
        w_data_d   = r_data_q;

        unique case (r_state_q)
            StIdle: begin
                if (start) begin
                    w_state_d  = StClear;
                    w_shadow_d = '0;
                    w_beat_d   = '0;
                    w_hold_d   = '0;
                end
            end
            StClear: begin
                if (abort) begin
                    w_state_d = StIdle;
                    w_hold_d  = '0;
                end else if (r_hold_q == LastHold) begin
                    w_state_d = StShift;
                    w_hold_d  = '0;
                end else begin
                    w_hold_d = r_hold_q + CntW'(1);
                end
            end
            StShift: begin
                // An abort discards any beat offered in the same cycle.
                if (abort) begin
                    w_state_d = StIdle;
                    w_beat_d  = '0;
                end else if (ser_valid) begin
                    w_shadow_d = r_shadow_q | (WIDTH'(ser_data) << r_beat_q);
                    if (r_beat_q == LastBeat) begin
                        w_state_d = StLatch;
                        w_beat_d  = '0;
                        w_data_d  = w_shadow_d;
                    end else begin
                        w_beat_d = r_beat_q + CntW'(1);
                    end
                end
            end
            StLatch: begin
                if (abort) begin
                    w_state_d = StIdle;
                    w_hold_d  = '0;
                end else if (r_hold_q == LastHold) begin
                    w_state_d = StDone;
                    w_hold_d  = '0;
                end else begin
                    w_hold_d = r_hold_q + CntW'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Outputs are registered copies of the next state so they line up with the state.
        w_clear_d  = (w_state_d == StClear);
        w_enable_d = (w_state_d == StLatch);
        w_ready_d  = (w_state_d == StShift);
        w_busy_d   = (w_state_d != StIdle);
        w_done_d   = (w_state_d == StDone);
    end

    always_ff @(posedge clocked_on or posedge preset) begin
        if (preset) begin
            r_state_q  <= StIdle;
            r_beat_q   <= '0;
            r_hold_q   <= '0;
            r_shadow_q <= '0;
            r_data_q   <= '0;
            r_clear_q  <= 1'b0;
            r_enable_q <= 1'b0;
            r_ready_q  <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_beat_q   <= w_beat_d;
            r_hold_q   <= w_hold_d;
            r_shadow_q <= w_shadow_d;
            r_data_q   <= w_data_d;
            r_clear_q  <= w_clear_d;
            r_enable_q <= w_enable_d;
            r_ready_q  <= w_ready_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign ser_ready  = r_ready_q;
    assign data_out   = r_data_q;
    assign enable_out = r_enable_q;
    assign clear_out  = r_clear_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;

endmodule

// File: tb/tb_umich_scan_loader.sv
// Directed bench for umich_scan_loader at WIDTH=16, HOLD_CYCLES=4.
// Each scenario task drives a sequence and checks the observed counts and data inline.
module tb_umich_scan_loader;

    logic        clocked_on = 1'b0;
    logic        preset     = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        ser_valid  = 1'b0;
    logic        ser_data   = 1'b0;
    logic        ser_ready;
    logic [15:0] data_out;
    logic        enable_out;
    logic        clear_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    int n_clear, n_shift, n_enable, n_done, latency, beats;
    bit timeout;

    umich_scan_loader #(
        .WIDTH      (16),
        .HOLD_CYCLES(4)
    ) u_dut (
        .clocked_on(clocked_on),
        .preset    (preset),
        .start     (start),
        .abort     (abort),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .data_out  (data_out),
        .enable_out(enable_out),
        .clear_out (clear_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clocked_on = ~clocked_on;

    // Global invariants: clear/enable exclusive, data_out frozen while enable_out is high.
    logic [15:0] mon_held = '0;
    logic        mon_en_prev = 1'b0;
    always @(negedge clocked_on) begin
        if (clear_out || enable_out) begin
            total++;
            if (clear_out && enable_out) begin
                bad++;
                $display("FAIL clr_en_overlap: clear_out=%b enable_out=%b, want not both", clear_out,
                         enable_out);
            end
        end
        if (enable_out && mon_en_prev) begin
            total++;
            if (data_out !== mon_held) begin
                bad++;
                $display("FAIL data_stable: data_out=%h, want %h", data_out, mon_held);
            end
        end
        mon_held    = data_out;
        mon_en_prev = enable_out;
    end

    // Runs one sequence from the start cycle; the start cycle itself is cycle 0 and latency
    // counts start cycle through done cycle inclusive.
    task automatic drive_seq(input logic [15:0] pat, input bit stall, input int abort_after,
                             input bit abort_final, input bit pulse_start, input int preset_at_en);
        int cyc;
        bit phase;
        bit acc;
        logic [3:0] idx;
        n_clear = 0; n_shift = 0; n_enable = 0; n_done = 0; latency = 0; beats = 0;
        timeout = 0; cyc = 0; phase = 0; acc = 0;
        start = 1'b1; abort = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
        forever begin
            @(posedge clocked_on);
            #1;
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (acc) beats++;
            if (clear_out) n_clear++;
            if (ser_ready) n_shift++;
            if (enable_out) n_enable++;
            if (done) begin
                n_done++;
                latency = cyc + 1;
            end
            if (preset_at_en > 0 && n_enable == preset_at_en) begin
                #2 preset = 1'b1;
                break;
            end
            if (!busy) break;
            if (cyc >= 200) begin
                timeout = 1;
                break;
            end
            if (ser_ready) begin
                ser_valid = stall ? phase : 1'b1;
                phase     = ~phase;
                idx       = beats[3:0];
                ser_data  = pat[idx];
                if (abort_after >= 0 && beats == abort_after) abort = 1'b1;
                if (abort_final && ser_valid && beats == 15) abort = 1'b1;
                if (pulse_start && beats == 3) start = 1'b1;
            end else begin
                // Offer junk beats outside SHIFT; none may be taken.
                ser_valid = 1'b1;
                ser_data  = 1'b1;
            end
            if (pulse_start && done) start = 1'b1;
            acc = ser_valid && ser_ready && !abort;
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic test_reset();
        #1 preset = 1'b1;
        #1;
        total++;
        if (data_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data: data_out=%h, want 0000", data_out);
        end
        total++;
        if ({clear_out, enable_out, ser_ready, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ctrl=%b, want 00000",
                     {clear_out, enable_out, ser_ready, busy, done});
        end
        start = 1'b1;
        repeat (2) @(posedge clocked_on);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: busy=%b, want 0", busy);
        end
        start  = 1'b0;
        preset = 1'b0;
        @(posedge clocked_on);
        #1;
    endtask

    task automatic test_load_no_stall();
        drive_seq(16'hA5C3, 1'b0, -1, 1'b0, 1'b0, 0);
        total++;
        if (timeout) begin bad++; $display("FAIL nostall_timeout: timed out, want finish"); end
        total++;
        if (n_clear != 4) begin bad++; $display("FAIL nostall_clear: %0d cycles, want 4", n_clear); end
        total++;
        if (n_shift != 16) begin bad++; $display("FAIL nostall_shift: %0d cycles, want 16", n_shift); end
        total++;
        if (beats != 16) begin bad++; $display("FAIL nostall_beats: %0d, want 16", beats); end
        total++;
        if (n_enable != 4) begin bad++; $display("FAIL nostall_enable: %0d, want 4", n_enable); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL nostall_done: %0d pulses, want 1", n_done); end
        total++;
        if (latency != 26) begin bad++; $display("FAIL nostall_latency: %0d, want 26", latency); end
        total++;
        if (data_out !== 16'hA5C3) begin
            bad++;
            $display("FAIL nostall_data: data_out=%h, want a5c3", data_out);
        end
    endtask

    task automatic test_start_ignored();
        drive_seq(16'h3C5A, 1'b0, -1, 1'b0, 1'b1, 0);
        total++;
        if (n_done != 1) begin bad++; $display("FAIL ignstart_done: %0d pulses, want 1", n_done); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ignstart_busy: busy=%b, want 0", busy); end
        total++;
        if (latency != 26) begin bad++; $display("FAIL ignstart_latency: %0d, want 26", latency); end
        total++;
        if (data_out !== 16'h3C5A) begin
            bad++;
            $display("FAIL ignstart_data: data_out=%h, want 3c5a", data_out);
        end
    endtask

    task automatic test_load_stalled();
        drive_seq(16'hA5C3, 1'b1, -1, 1'b0, 1'b0, 0);
        total++;
        if (n_shift != 32) begin bad++; $display("FAIL stall_shift: %0d cycles, want 32", n_shift); end
        total++;
        if (beats != 16) begin bad++; $display("FAIL stall_beats: %0d, want 16", beats); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL stall_done: %0d pulses, want 1", n_done); end
        total++;
        if (data_out !== 16'hA5C3) begin
            bad++;
            $display("FAIL stall_data: data_out=%h, want a5c3", data_out);
        end
    endtask

    task automatic test_abort();
        drive_seq(16'hFFFF, 1'b0, -1, 1'b0, 1'b0, 0);
        total++;
        if (data_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL abort_preload: data_out=%h, want ffff", data_out);
        end
        drive_seq(16'h0000, 1'b0, 8, 1'b0, 1'b0, 0);
        total++;
        if (beats != 8) begin bad++; $display("FAIL abort_beats: %0d, want 8", beats); end
        total++;
        if (n_done != 0 || n_enable != 0) begin
            bad++;
            $display("FAIL abort_pulses: done=%0d enable=%0d, want 0 0", n_done, n_enable);
        end
        total++;
        if ({busy, ser_ready, clear_out} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle: busy/ready/clear=%b, want 000", {busy, ser_ready, clear_out});
        end
        total++;
        if (data_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL abort_data: data_out=%h, want ffff", data_out);
        end
    endtask

    task automatic test_abort_final_beat();
        drive_seq(16'h1234, 1'b0, -1, 1'b1, 1'b0, 0);
        total++;
        if (n_done != 0 || n_enable != 0) begin
            bad++;
            $display("FAIL abortfin_pulses: done=%0d enable=%0d, want 0 0", n_done, n_enable);
        end
        total++;
        if (data_out !== 16'hFFFF) begin
            bad++;
            $display("FAIL abortfin_data: data_out=%h, want ffff", data_out);
        end
    endtask

    task automatic test_preset_in_latch();
        drive_seq(16'h5555, 1'b0, -1, 1'b0, 1'b0, 2);
        #1;
        total++;
        if (data_out !== 16'h0000) begin
            bad++;
            $display("FAIL preset_data: data_out=%h, want 0000", data_out);
        end
        total++;
        if ({clear_out, enable_out, ser_ready, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL preset_ctrl: ctrl=%b, want 00000",
                     {clear_out, enable_out, ser_ready, busy, done});
        end
        #2 preset = 1'b0;
        // Start goes up in the same cycle so the first edge with preset low must take it.
        drive_seq(16'h0001, 1'b0, -1, 1'b0, 1'b0, 0);
        total++;
        if (latency != 26) begin bad++; $display("FAIL postpreset_latency: %0d, want 26", latency); end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL postpreset_done: %0d, want 1", n_done); end
        total++;
        if (data_out !== 16'h0001) begin
            bad++;
            $display("FAIL postpreset_data: data_out=%h, want 0001", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_load_no_stall();
        test_start_ignored();
        test_load_stalled();
        test_abort();
        test_abort_final_beat();
        test_preset_in_latch();
        repeat (2) @(posedge clocked_on);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
